// File: rtl/btn_event_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : btn_event_arbiter                                          |
// | Description : Classifies debounced button levels into SHORT/LONG/REPEAT  |
// |               events and arbitrates them round-robin onto one valid/     |
// |               ready channel. Define BTN_AUTO_REPEAT_EN for REPEAT events.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module btn_event_arbiter #(
  parameter int NUM_BTN   = 4,
  parameter int TICK_DIV  = 100_000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic [NUM_BTN-1:0]         iBtnLvl,
  input  logic                       iEvtReady,
  output logic                       oEvtValid,
  output logic [$clog2(NUM_BTN)-1:0] oEvtId,
  output logic [1:0]                 oEvtType,
  output logic                       oOvf
);

  localparam int c_ID_W   = $clog2(NUM_BTN);
  localparam int c_TICK_W = $clog2(TICK_DIV);
  localparam int c_MS_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int c_MS_W   = (c_MS_MAX > 1) ? $clog2(c_MS_MAX) : 1;

  localparam logic [1:0] c_EVT_NONE   = 2'b00;
  localparam logic [1:0] c_EVT_SHORT  = 2'b01;
  localparam logic [1:0] c_EVT_LONG   = 2'b10;
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [1:0] c_EVT_REPEAT = 2'b11;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  logic [c_TICK_W-1:0]     r_tick;
  logic                    w_msTick;
  logic [NUM_BTN-1:0]      r_prev;
  logic [NUM_BTN-1:0]      w_post;
  logic [NUM_BTN-1:0][1:0] w_postType;

  logic [NUM_BTN-1:0]      r_pendV;
  logic [NUM_BTN-1:0][1:0] r_pendT;
  logic [NUM_BTN-1:0]      w_pendVNxt;
  logic [NUM_BTN-1:0][1:0] w_pendTNxt;
  logic [c_ID_W-1:0]       r_ptr;
  logic                    r_evtValid;
  logic [c_ID_W-1:0]       r_evtId;
  logic [1:0]              r_evtType;
  logic                    r_ovf;

  logic                    w_accept;
  logic                    w_lock;
  logic [NUM_BTN-1:0]      w_acceptMask;
  logic [c_ID_W-1:0]       w_ptrInc;
  logic [c_ID_W-1:0]       w_arbPtr;
  logic [NUM_BTN-1:0]      w_arbV;
  logic                    w_ovf;
  logic                    w_gntFound;
  logic [c_ID_W-1:0]       w_gntId;
  logic [1:0]              w_gntType;
  int                      w_scanIdx;

  assign w_msTick = (r_tick == c_TICK_W'(TICK_DIV - 1));

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_tick <= '0;
      r_prev <= '0;
    end else begin
      r_tick <= w_msTick ? '0 : r_tick + 1'b1;
      r_prev <= iBtnLvl;
    end
  end

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    state_t            r_state;
    logic [c_MS_W-1:0] r_ms;
    logic              w_rise;
    logic              w_fall;
    logic              w_longHit;
    logic              w_postL;
    logic [1:0]        w_typeL;

    assign w_rise    = iBtnLvl[gi] & ~r_prev[gi];
    assign w_fall    = ~iBtnLvl[gi] & r_prev[gi];
    assign w_longHit = w_msTick && (r_ms == c_MS_W'(LONG_MS - 1));
`ifdef BTN_AUTO_REPEAT_EN
    logic w_repHit;
    assign w_repHit  = w_msTick && (r_ms == c_MS_W'(REPEAT_MS - 1));
`endif

    // Release is checked first so it wins over a coincident threshold.
    always_comb begin
      w_postL = 1'b0;
      w_typeL = c_EVT_NONE;
      case (r_state)
        ST_PRESS: begin
          if (w_fall) begin
            w_postL = 1'b1;
            w_typeL = c_EVT_SHORT;
          end else if (w_longHit) begin
            w_postL = 1'b1;
            w_typeL = c_EVT_LONG;
          end
        end
`ifdef BTN_AUTO_REPEAT_EN
        ST_HOLD: begin
          if (!w_fall && w_repHit) begin
            w_postL = 1'b1;
            w_typeL = c_EVT_REPEAT;
          end
        end
`endif
        default: ;
      endcase
    end

    assign w_post[gi]     = w_postL;
    assign w_postType[gi] = w_typeL;

    always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
        r_state <= ST_IDLE;
        r_ms    <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              r_state <= ST_PRESS;
              r_ms    <= '0;
            end
          end
          ST_PRESS: begin
            if (w_fall) begin
              r_state <= ST_IDLE;
            end else if (w_longHit) begin
              r_state <= ST_HOLD;
              r_ms    <= '0;
            end else if (w_msTick) begin
              r_ms <= r_ms + 1'b1;
            end
          end
          ST_HOLD: begin
            if (w_fall) begin
              r_state <= ST_IDLE;
`ifdef BTN_AUTO_REPEAT_EN
            end else if (w_repHit) begin
              r_ms <= '0;
            end else if (w_msTick) begin
              r_ms <= r_ms + 1'b1;
`endif
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign w_accept     = r_evtValid & iEvtReady;
  assign w_lock       = r_evtValid & ~iEvtReady;
  assign w_acceptMask = w_accept ? (NUM_BTN'(1) << r_evtId) : '0;
  assign w_ptrInc     = (r_evtId == c_ID_W'(NUM_BTN - 1)) ? '0 : r_evtId + 1'b1;
  assign w_arbPtr     = w_accept ? w_ptrInc : r_ptr;
  assign w_arbV       = r_pendV & ~w_acceptMask;

  // A post landing on the slot being accepted re-arms it without overflow.
  always_comb begin
    w_pendVNxt = r_pendV & ~w_acceptMask;
    w_pendTNxt = r_pendT;
    w_ovf      = 1'b0;
    for (int b = 0; b < NUM_BTN; b++) begin
      if (w_post[b]) begin
        if (r_pendV[b] && !w_acceptMask[b]) begin
          w_ovf = 1'b1;
        end
        w_pendVNxt[b] = 1'b1;
        w_pendTNxt[b] = w_postType[b];
      end
    end
  end

  always_comb begin
    w_gntFound = 1'b0;
    w_gntId    = '0;
    w_scanIdx  = 0;
    for (int o = 0; o < NUM_BTN; o++) begin
      w_scanIdx = int'(w_arbPtr) + o;
      if (w_scanIdx >= NUM_BTN) begin
        w_scanIdx = w_scanIdx - NUM_BTN;
      end
      if (!w_gntFound && w_arbV[w_scanIdx]) begin
        w_gntFound = 1'b1;
        w_gntId    = c_ID_W'(w_scanIdx);
      end
    end
    w_gntType = w_gntFound ? w_pendTNxt[w_gntId] : c_EVT_NONE;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_pendV    <= '0;
      r_pendT    <= '0;
      r_ptr      <= '0;
      r_evtValid <= 1'b0;
      r_evtId    <= '0;
      r_evtType  <= c_EVT_NONE;
      r_ovf      <= 1'b0;
    end else begin
      r_pendV <= w_pendVNxt;
      r_pendT <= w_pendTNxt;
      r_ovf   <= w_ovf;
      if (w_accept) begin
        r_ptr <= w_ptrInc;
      end
      if (!w_lock) begin
        r_evtValid <= w_gntFound;
        r_evtId    <= w_gntId;
        r_evtType  <= w_gntType;
      end
    end
  end

  assign oEvtValid = r_evtValid;
  assign oEvtId    = r_evtId;
  assign oEvtType  = r_evtType;
  assign oOvf      = r_ovf;

endmodule
`default_nettype wire
